tlu_handshake_rx: RTL and testbench

// - DUT-side responder for the EUDET-style TLU trigger handshake on the RJ45 link (TRIGGER/BUSY/CLOCK/RESET).
// - On a TLU trigger: asserts BUSY, clocks the trigger number out of the TLU, and packs it into a 32-bit word.
// - Queues the word for the readout arbiter, then releases BUSY.
// - Sits in the FPGA core between the RJ45 pins and the data arbiter, beside the chip data receiver.

---
 rtl/tlu_rx_pkg.sv | 21 ++
 rtl/generic_fifo.sv | 54 +++++
 rtl/tlu_handshake_rx.sv | 254 +++++++++++++++++++++++++
 tb/tb_tlu_handshake_rx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_rx_pkg.sv
// Shared definitions for the TLU trigger-handshake receiver.
//   state_e       : handshake FSM states
//   TRG_WORD_FLAG : marker bit set in every trigger word pushed to the readout queue
//   MIN_CLK_DIV   : smallest usable TLU_CLOCK half period (BUS_CLK cycles); covers the
//                   2-FF synchroniser delay on the returning data line
//   DEFAULT_BITS  : trigger-number width used when TRIGGER_BITS is 0
package tlu_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_WAIT,
    SHIFT,
    STORE,
    RELEASE
  } state_e;

  localparam logic [31:0] TRG_WORD_FLAG = 32'h8000_0000;
  localparam logic [7:0]  MIN_CLK_DIV   = 8'd4;
  localparam logic [4:0]  DEFAULT_BITS  = 5'd15;

endpackage

// File: rtl/generic_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
//   clk, rst : clock, synchronous active-high reset (pointers only)
//   wr_en    : push wr_data; accepted when not full, or when full and a pop happens too
//   rd_en    : pop the head word; ignored while empty
//   rd_data  : head word, valid whenever empty=0 (forced to 0 while empty)
//   empty    : no word held
//   full     : DEPTH words held
module generic_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/tlu_handshake_rx.sv
// DUT-side responder for the EUDET-style TLU trigger handshake.
// On a trigger it raises TLU_BUSY, clocks the trigger number out of the TLU
// LSB first, queues {1'b1, number} for the readout arbiter and releases BUSY.
//   BUS_CLK, BUS_RST      : clock, synchronous active-high reset
//   ENABLE                : accept new triggers (a running handshake always completes)
//   TRIGGER_BITS, CLK_DIV : number width (0 -> 15), TLU_CLOCK half period (<4 -> 4)
//   TIMEOUT               : max RELEASE cycles waiting for TLU_TRIGGER low
//   TLU_TRIGGER, TLU_RESET: asynchronous inputs from the RJ45 link
//   TLU_BUSY, TLU_CLOCK   : handshake outputs to the TLU
//   TLU_RESET_PULSE       : 1-cycle pulse per synchronised TLU_RESET rising edge
//   FIFO_READ/EMPTY/DATA  : first-word-fall-through queue towards the arbiter
//   *_COUNT               : handshake, lost-word, skipped-number and timeout statistics
module tlu_handshake_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 ENABLE,
  input  logic [4:0]           TRIGGER_BITS,
  input  logic [7:0]           CLK_DIV,
  input  logic [TIMEOUT_W-1:0] TIMEOUT,
  input  logic                 TLU_TRIGGER,
  input  logic                 TLU_RESET,
  output logic                 TLU_BUSY,
  output logic                 TLU_CLOCK,
  output logic                 TLU_RESET_PULSE,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [31:0]          FIFO_DATA,
  output logic [31:0]          TRIGGER_COUNT,
  output logic [15:0]          LOST_COUNT,
  output logic [15:0]          SKIP_COUNT,
  output logic [15:0]          TIMEOUT_COUNT
);

  import tlu_rx_pkg::*;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic trg_s1_q, trg_s2_q, trg_s3_q;
  logic rst_s1_q, rst_s2_q, rst_s3_q;
  logic trg_rise, rst_rise;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 tclk_q, tclk_d;
  logic                 phase_q, phase_d;     // 0: TLU_CLOCK high half, 1: low half
  logic [7:0]           cnt_q, cnt_d;
  logic [4:0]           bit_q, bit_d;
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
  logic [TIMEOUT_W:0]   tcnt_inc;
  logic [30:0]          shift_q, shift_d;
  logic [30:0]          prev_q, prev_d;
  logic                 prev_vld_q, prev_vld_d;
  logic                 pend_clr_q, pend_clr_d;
  logic                 rpulse_q, rpulse_d;
  logic [31:0]          trig_cnt_q, trig_cnt_d;
  logic [15:0]          lost_q, lost_d;
  logic [15:0]          skip_q, skip_d;
  logic [15:0]          tmo_q, tmo_d;

  logic [7:0]  div_eff;
  logic [4:0]  nbits_eff;
  logic        cnt_last;
  logic        store, timeout_hit, fifo_full;
  logic [30:0] num_mask, prev_next;
  logic [31:0] word;

  assign trg_rise  = trg_s2_q & ~trg_s3_q;
  assign rst_rise  = rst_s2_q & ~rst_s3_q;
  assign div_eff   = (CLK_DIV < MIN_CLK_DIV) ? MIN_CLK_DIV : CLK_DIV;
  assign nbits_eff = (TRIGGER_BITS == 5'd0) ? DEFAULT_BITS : TRIGGER_BITS;
  assign cnt_last  = (cnt_q == div_eff - 8'd1);
  assign num_mask  = 31'h7FFF_FFFF >> (5'd31 - nbits_eff);
  assign prev_next = (prev_q + 31'd1) & num_mask;
  assign word      = TRG_WORD_FLAG | {1'b0, shift_q};
  assign tcnt_inc  = {1'b0, tcnt_q} + {{TIMEOUT_W{1'b0}}, 1'b1};

  // Handshake FSM and TLU_CLOCK divider
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    tclk_d      = tclk_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tcnt_d      = tcnt_q;
    shift_d     = shift_q;
    store       = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        shift_d = '0;
        cnt_d   = '0;
        bit_d   = '0;
        phase_d = 1'b0;
        tclk_d  = 1'b0;
        if (trg_rise && ENABLE) begin
          state_d = BUSY_WAIT;
          busy_d  = 1'b1;
        end
      end
      BUSY_WAIT: begin
        if (cnt_last) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tclk_d  = 1'b1;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (!cnt_last) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = '0;
          if (!phase_q) begin
            // last high cycle: the TLU has had the whole half period to settle the bit
            shift_d[bit_q] = trg_s2_q;
            tclk_d         = 1'b0;
            phase_d        = 1'b1;
          end else if (bit_q == nbits_eff - 5'd1) begin
            state_d = STORE;
          end else begin
            bit_d   = bit_q + 5'd1;
            tclk_d  = 1'b1;
            phase_d = 1'b0;
          end
        end
      end
      STORE: begin
        store   = 1'b1;
        busy_d  = 1'b0;
        tcnt_d  = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!trg_s2_q) begin
          state_d = IDLE;
        end else if (tcnt_inc >= {1'b0, TIMEOUT}) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          tcnt_d = tcnt_inc[TIMEOUT_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Statistics and previous-number tracking
  always_comb begin
    trig_cnt_d = trig_cnt_q;
    lost_d     = lost_q;
    skip_d     = skip_q;
    tmo_d      = tmo_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    pend_clr_d = pend_clr_q;
    rpulse_d   = rst_rise;
    if (store) begin
      trig_cnt_d = trig_cnt_q + 32'd1;
      // a pop in the same cycle frees the slot, so only a full queue without a read drops
      if (fifo_full && !FIFO_READ) lost_d = sat_inc(lost_q);
      if (prev_vld_q && (shift_q != prev_next)) skip_d = sat_inc(skip_q);
      prev_d     = shift_q;
      prev_vld_d = 1'b1;
    end
    if (timeout_hit) tmo_d = sat_inc(tmo_q);
    if (pend_clr_q && (state_q != IDLE) && (state_d == IDLE)) begin
      trig_cnt_d = '0;
      pend_clr_d = 1'b0;
    end
    if (rst_rise) begin
      prev_vld_d = 1'b0;
      // clearing mid-handshake would lose the count of the handshake in flight
      if ((state_q == IDLE) || (state_d == IDLE)) begin
        trig_cnt_d = '0;
        pend_clr_d = 1'b0;
      end else begin
        pend_clr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge BUS_CLK) begin
    trg_s1_q <= TLU_TRIGGER;
    trg_s2_q <= trg_s1_q;
    trg_s3_q <= trg_s2_q;
    rst_s1_q <= TLU_RESET;
    rst_s2_q <= rst_s1_q;
    rst_s3_q <= rst_s2_q;
    shift_q  <= shift_d;
    prev_q   <= prev_d;
    if (BUS_RST) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      tclk_q     <= 1'b0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      bit_q      <= '0;
      tcnt_q     <= '0;
      prev_vld_q <= 1'b0;
      pend_clr_q <= 1'b0;
      rpulse_q   <= 1'b0;
      trig_cnt_q <= '0;
      lost_q     <= '0;
      skip_q     <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      tclk_q     <= tclk_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tcnt_q     <= tcnt_d;
      prev_vld_q <= prev_vld_d;
      pend_clr_q <= pend_clr_d;
      rpulse_q   <= rpulse_d;
      trig_cnt_q <= trig_cnt_d;
      lost_q     <= lost_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
    end
  end

  generic_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (BUS_CLK),
    .rst     (BUS_RST),
    .wr_en   (store),
    .wr_data (word),
    .rd_en   (FIFO_READ),
    .rd_data (FIFO_DATA),
    .empty   (FIFO_EMPTY),
    .full    (fifo_full)
  );

  assign TLU_BUSY        = busy_q;
  assign TLU_CLOCK       = tclk_q;
  assign TLU_RESET_PULSE = rpulse_q;
  assign TRIGGER_COUNT   = trig_cnt_q;
  assign LOST_COUNT      = lost_q;
  assign SKIP_COUNT      = skip_q;
  assign TIMEOUT_COUNT   = tmo_q;

endmodule

// File: tb/tb_tlu_handshake_rx.sv
module tb_tlu_handshake_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [4:0]  trg_bits = 5'd15;
  logic [7:0]  clk_div = 8'd4;
  logic [15:0] timeout = 16'd1000;
  logic        tlu_trigger = 1'b0;
  logic        tlu_reset = 1'b0;
  logic        fifo_read = 1'b0;
  logic        tlu_busy, tlu_clock, rst_pulse, fifo_empty;
  logic [31:0] fifo_data, trigger_count;
  logic [15:0] lost_count, skip_count, timeout_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlu_handshake_rx #(.FIFO_DEPTH(8), .TIMEOUT_W(16)) dut (
    .BUS_CLK         (clk),
    .BUS_RST         (rst),
    .ENABLE          (enable),
    .TRIGGER_BITS    (trg_bits),
    .CLK_DIV         (clk_div),
    .TIMEOUT         (timeout),
    .TLU_TRIGGER     (tlu_trigger),
    .TLU_RESET       (tlu_reset),
    .TLU_BUSY        (tlu_busy),
    .TLU_CLOCK       (tlu_clock),
    .TLU_RESET_PULSE (rst_pulse),
    .FIFO_READ       (fifo_read),
    .FIFO_EMPTY      (fifo_empty),
    .FIFO_DATA       (fifo_data),
    .TRIGGER_COUNT   (trigger_count),
    .LOST_COUNT      (lost_count),
    .SKIP_COUNT      (skip_count),
    .TIMEOUT_COUNT   (timeout_count)
  );

  // TLU model: strobe, wait for BUSY, put bit i on the line at the i-th TLU_CLOCK rise,
  // drive 'hold' after the last fall, return once BUSY drops.
  task automatic send_trigger(input logic [30:0] num, input int nbits, input logic hold,
                              input int drop_at, output int lat, output int pulses, output int hi);
    logic pc;
    int   c;
    lat = 0; pulses = 0; hi = 0; pc = 1'b0; c = 0;
    @(negedge clk);
    tlu_trigger = 1'b1;
    while (!tlu_busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!tlu_busy) begin
      total++; bad++;
      $display("FAIL hs_start busy=%0b want=1", tlu_busy);
      tlu_trigger = 1'b0;
      return;
    end
    while (tlu_busy && c < 3000) begin
      @(negedge clk);
      c++;
      if (tlu_clock && !pc) begin
        if (pulses < nbits) tlu_trigger = num[pulses];
        pulses++;
        if (pulses == drop_at) enable = 1'b0;
      end
      if (!tlu_clock && pc && pulses >= nbits) tlu_trigger = hold;
      if (tlu_clock) hi++;
      pc = tlu_clock;
    end
    if (tlu_busy) begin
      total++; bad++;
      $display("FAIL hs_end busy=%0b want=0", tlu_busy);
    end
    if (!hold) repeat (5) @(negedge clk);
  endtask

  task automatic pop_word(output logic [31:0] w);
    @(negedge clk);
    w = fifo_data;
    fifo_read = 1'b1;
    @(negedge clk);
    fifo_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (tlu_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", tlu_busy); end
    total++; if (tlu_clock !== 1'b0) begin bad++; $display("FAIL rst_clock got=%0b want=0", tlu_clock); end
    total++; if (rst_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse got=%0b want=0", rst_pulse); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b want=1", fifo_empty); end
    total++; if (fifo_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", fifo_data); end
    total++; if ({trigger_count, lost_count, skip_count, timeout_count} !== 80'h0) begin
      bad++; $display("FAIL rst_counters got=%h/%h/%h/%h want=0", trigger_count, lost_count, skip_count, timeout_count);
    end
  endtask

  task automatic test_basic();
    int lat, p, hi;
    logic [31:0] w;
    send_trigger(31'h1234, 15, 1'b0, 0, lat, p, hi);
    total++; if (lat != 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", lat); end
    total++; if (p != 15) begin bad++; $display("FAIL basic_pulses got=%0d want=15", p); end
    total++; if (hi != 60) begin bad++; $display("FAIL basic_high_cycles got=%0d want=60", hi); end
    total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0b want=0", fifo_empty); end
    total++; if (trigger_count !== 32'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", trigger_count); end
    pop_word(w);
    total++; if (w !== 32'h8000_1234) begin bad++; $display("FAIL basic_word got=%h want=80001234", w); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL basic_drained got=%0b want=1", fifo_empty); end
  endtask

  task automatic test_tlu_reset();
    int n;
    n = 0;
    @(negedge clk);
    tlu_reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rst_pulse) n++;
    end
    tlu_reset = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (n != 1) begin bad++; $display("FAIL tlurst_pulse_cycles got=%0d want=1", n); end
    total++; if (trigger_count !== 32'd0) begin bad++; $display("FAIL tlurst_count got=%0d want=0", trigger_count); end
  endtask

  task automatic test_skip();
    int lat, p, hi;
    logic [31:0] w;
    logic [30:0] nums [3];
    nums[0] = 31'd5; nums[1] = 31'd6; nums[2] = 31'd8;
    for (int i = 0; i < 3; i++) send_trigger(nums[i], 15, 1'b0, 0, lat, p, hi);
    total++; if (skip_count !== 16'd1) begin bad++; $display("FAIL skip_count got=%0d want=1", skip_count); end
    total++; if (trigger_count !== 32'd3) begin bad++; $display("FAIL skip_trig_count got=%0d want=3", trigger_count); end
    for (int i = 0; i < 3; i++) begin
      pop_word(w);
      total++;
      if (w !== {1'b1, nums[i]}) begin bad++; $display("FAIL skip_word%0d got=%h want=%h", i, w, {1'b1, nums[i]}); end
    end
  endtask

  task automatic test_overflow();
    int lat, p, hi;
    logic [31:0] w;
    for (int i = 0; i < 10; i++) begin
      send_trigger(31'(9 + i), 15, 1'b0, 0, lat, p, hi);
      total++; if (lat != 3) begin bad++; $display("FAIL ovf_busy%0d latency got=%0d want=3", i, lat); end
    end
    total++; if (lost_count !== 16'd2) begin bad++; $display("FAIL ovf_lost got=%0d want=2", lost_count); end
    total++; if (trigger_count !== 32'd13) begin bad++; $display("FAIL ovf_count got=%0d want=13", trigger_count); end
    total++; if (skip_count !== 16'd1) begin bad++; $display("FAIL ovf_skip got=%0d want=1", skip_count); end
    for (int i = 0; i < 8; i++) begin
      pop_word(w);
      total++;
      if (w !== (32'h8000_0000 | 32'(9 + i))) begin bad++; $display("FAIL ovf_word%0d got=%h want=%h", i, w, 32'h8000_0000 | 32'(9 + i)); end
    end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%0b want=1", fifo_empty); end
  endtask

  task automatic test_timeout();
    int lat, p, hi, c;
    logic seen;
    logic [31:0] w;
    timeout = 16'd100;
    send_trigger(31'd19, 15, 1'b1, 0, lat, p, hi);
    c = 0;
    while (timeout_count == 16'd0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    total++; if (c != 100) begin bad++; $display("FAIL tmo_cycles got=%0d want=100", c); end
    total++; if (timeout_count !== 16'd1) begin bad++; $display("FAIL tmo_count got=%0d want=1", timeout_count); end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tlu_busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL tmo_no_rearm busy_seen=%0b want=0", seen); end
    tlu_trigger = 1'b0;
    repeat (4) @(negedge clk);
    send_trigger(31'd20, 15, 1'b0, 0, lat, p, hi);
    total++; if (lat != 3) begin bad++; $display("FAIL tmo_rearm_latency got=%0d want=3", lat); end
    total++; if (trigger_count !== 32'd15) begin bad++; $display("FAIL tmo_trig_count got=%0d want=15", trigger_count); end
    pop_word(w);
    total++; if (w !== 32'h8000_0013) begin bad++; $display("FAIL tmo_word got=%h want=80000013", w); end
    timeout = 16'd1000;
  endtask

  task automatic test_bus_reset();
    int c, rises, lat, p, hi;
    logic pc;
    logic [31:0] w;
    @(negedge clk);
    tlu_trigger = 1'b1;
    c = 0;
    while (!tlu_busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    rises = 0; pc = 1'b0; c = 0;
    while (rises < 8 && c < 500) begin
      @(negedge clk);
      c++;
      if (tlu_clock && !pc) rises++;
      pc = tlu_clock;
    end
    total++; if (rises != 8) begin bad++; $display("FAIL brst_rises got=%0d want=8", rises); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (tlu_busy !== 1'b0) begin bad++; $display("FAIL brst_busy got=%0b want=0", tlu_busy); end
    total++; if (tlu_clock !== 1'b0) begin bad++; $display("FAIL brst_clock got=%0b want=0", tlu_clock); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL brst_empty got=%0b want=1", fifo_empty); end
    total++; if (trigger_count !== 32'd0) begin bad++; $display("FAIL brst_count got=%0d want=0", trigger_count); end
    @(negedge clk);
    rst = 1'b0;
    tlu_trigger = 1'b0;
    repeat (4) @(negedge clk);
    send_trigger(31'h2AAA, 15, 1'b0, 0, lat, p, hi);
    total++; if (trigger_count !== 32'd1) begin bad++; $display("FAIL brst_after_count got=%0d want=1", trigger_count); end
    pop_word(w);
    total++; if (w !== 32'h8000_2AAA) begin bad++; $display("FAIL brst_after_word got=%h want=80002aaa", w); end
  endtask

  task automatic test_enable();
    int lat, p, hi;
    logic seen;
    logic [31:0] w;
    enable = 1'b0;
    @(negedge clk);
    tlu_trigger = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (tlu_busy) seen = 1'b1; end
    enable = 1'b1;
    repeat (10) begin @(negedge clk); if (tlu_busy) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL en_ignored busy_seen=%0b want=0", seen); end
    tlu_trigger = 1'b0;
    repeat (4) @(negedge clk);
    send_trigger(31'h2AAB, 15, 1'b0, 5, lat, p, hi);
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL en_drop_applied got=%0b want=0", enable); end
    total++; if (trigger_count !== 32'd2) begin bad++; $display("FAIL en_drop_count got=%0d want=2", trigger_count); end
    pop_word(w);
    total++; if (w !== 32'h8000_2AAB) begin bad++; $display("FAIL en_drop_word got=%h want=80002aab", w); end
    enable = 1'b1;
  endtask

  task automatic test_boundary();
    int lat, p, hi;
    logic [31:0] w;
    trg_bits = 5'd0;
    clk_div  = 8'd2;
    send_trigger(31'h2AAC, 15, 1'b0, 0, lat, p, hi);
    total++; if (p != 15) begin bad++; $display("FAIL bnd_bits0_pulses got=%0d want=15", p); end
    total++; if (hi != 60) begin bad++; $display("FAIL bnd_div2_high got=%0d want=60", hi); end
    pop_word(w);
    total++; if (w !== 32'h8000_2AAC) begin bad++; $display("FAIL bnd_word15 got=%h want=80002aac", w); end
    trg_bits = 5'd8;
    clk_div  = 8'd4;
    send_trigger(31'hAD, 8, 1'b0, 0, lat, p, hi);
    total++; if (hi != 32) begin bad++; $display("FAIL bnd_bits8_high got=%0d want=32", hi); end
    pop_word(w);
    total++; if (w !== 32'h8000_00AD) begin bad++; $display("FAIL bnd_word8 got=%h want=800000ad", w); end
    total++; if (skip_count !== 16'd0) begin bad++; $display("FAIL bnd_mod_skip got=%0d want=0", skip_count); end
    trg_bits = 5'd15;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tlu_reset();
    test_skip();
    test_overflow();
    test_timeout();
    test_bus_reset();
    test_enable();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t limit=500000", $time);
    $fatal(1);
  end

endmodule
